// File: rtl/gate_arb_pkg.sv
// Shared op codes and the bitwise gate primitive for gate_unit_arbiter.
// Optional requester lock is enabled by defining GATE_ARB_LOCK_EN.
package gate_arb_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_NAND = 2'd3
    } gate_op_e;

    // One bit lane of the gate; no carries, so lanes are independent.
    function automatic logic gate_bit(gate_op_e op, logic a, logic b);
        logic r;
        unique case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_unit_arbiter_rr_pick.sv
// Round-robin picker: first set bit of elig at or above ptr, wrapping.
// Purely combinational, sized by N.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   elig,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   onehot,
    output logic [IDW-1:0] idx,
    output logic           any
);

    int j;

    // Walk N slots starting at ptr; the first eligible slot wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        j      = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && elig[j]) begin
                any       = 1'b1;
                idx       = IDW'(j);
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gate_unit_arbiter.sv
// Round-robin shared bitwise gate unit with a 2-stage pipe and valid/ready out.
// Define GATE_ARB_LOCK_EN to add the per-requester lock input.
module gate_unit_arbiter
    import gate_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] op_a,
    input  logic [NREQ*W-1:0] op_b,
    input  logic [NREQ*2-1:0] op_sel,
`ifdef GATE_ARB_LOCK_EN
    input  logic [NREQ-1:0]   lock,
`endif
    output logic [NREQ-1:0]   gnt,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_data
);

    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic            s1_valid_q, s1_valid_d;
    logic [W-1:0]    s1_a_q, s1_a_d;
    logic [W-1:0]    s1_b_q, s1_b_d;
    gate_op_e        s1_op_q, s1_op_d;
    logic [IDW-1:0]  s1_id_q, s1_id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [W-1:0]    rsp_data_q, rsp_data_d;

    logic            stall;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] pick_oh;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;
    logic            win_any;
    logic [IDW-1:0]  win_idx;
    logic [NREQ-1:0] win_oh;
    logic [W-1:0]    s2_res;

`ifdef GATE_ARB_LOCK_EN
    logic            win_lock;
    logic            last_v_q, last_v_d;
    logic [IDW-1:0]  last_id_q, last_id_d;
`endif

    assign stall = rsp_valid_q & ~rsp_ready;
    assign elig  = req & ~gnt_q;

    rr_pick #(
        .N   (NREQ),
        .IDW (IDW)
    ) u_pick (
        .elig   (elig),
        .ptr    (ptr_q),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Choose the winner: a held lock beats round robin.
    always_comb begin
        win_any = pick_any;
        win_idx = pick_idx;
        win_oh  = pick_oh;
`ifdef GATE_ARB_LOCK_EN
        win_lock = 1'b0;
        if (last_v_q && req[last_id_q] && lock[last_id_q]) begin
            win_lock         = 1'b1;
            win_any          = 1'b1;
            win_idx          = last_id_q;
            win_oh           = '0;
            win_oh[last_id_q] = 1'b1;
        end
`endif
    end

    // Stage-2 gate evaluation, one bit lane at a time.
    always_comb begin
        s2_res = '0;
        for (int i = 0; i < W; i++) begin
            s2_res[i] = gate_bit(s1_op_q, s1_a_q[i], s1_b_q[i]);
        end
    end

    // Next state: everything holds on a stall except gnt, which drops.
    always_comb begin
        gnt_d       = '0;
        ptr_d       = ptr_q;
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_op_d     = s1_op_q;
        s1_id_d     = s1_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
`ifdef GATE_ARB_LOCK_EN
        last_v_d    = last_v_q;
        last_id_d   = last_id_q;
`endif
        if (!stall) begin
            rsp_valid_d = s1_valid_q;
            rsp_data_d  = s2_res;
            rsp_id_d    = s1_id_q;
            s1_valid_d  = win_any;
            if (win_any) begin
                gnt_d   = win_oh;
                s1_a_d  = op_a[win_idx*W +: W];
                s1_b_d  = op_b[win_idx*W +: W];
                s1_op_d = gate_op_e'(op_sel[win_idx*2 +: 2]);
                s1_id_d = win_idx;
                ptr_d   = (win_idx == IDW'(NREQ-1)) ? '0
                        : win_idx + IDW'(1);
`ifdef GATE_ARB_LOCK_EN
                if (win_lock) ptr_d = ptr_q;
                last_v_d  = 1'b1;
                last_id_d = win_idx;
`endif
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_q       <= '0;
            ptr_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= OP_AND;
            s1_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
`ifdef GATE_ARB_LOCK_EN
            last_v_q    <= 1'b0;
            last_id_q   <= '0;
`endif
        end else begin
            gnt_q       <= gnt_d;
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            s1_id_q     <= s1_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
`ifdef GATE_ARB_LOCK_EN
            last_v_q    <= last_v_d;
            last_id_q   <= last_id_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Scoreboard bench for gate_unit_arbiter: reference grants and results
// predicted from the arbitration rules, responses checked by a monitor.
module tb_gate_unit_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] op_a;
    logic [NREQ*W-1:0] op_b;
    logic [NREQ*2-1:0] op_sel;
`ifdef GATE_ARB_LOCK_EN
    logic [NREQ-1:0]   lock;
`endif
    logic [NREQ-1:0]   gnt;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_data;

    gate_unit_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sel    (op_sel),
`ifdef GATE_ARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           id;
        logic [W-1:0] d;
    } exp_t;

    exp_t            exp_q[$];
    int              tests = 0;
    int              fails = 0;

    int              m_ptr;
    logic [NREQ-1:0] m_gnt;
    bit              m_s1v;
    bit              m_outv;
    int              m_last;
    bit              m_last_v;

    function automatic logic [W-1:0] ref_op(int op, logic [W-1:0] a,
                                            logic [W-1:0] b);
        case (op)
            0:       return a & b;
            1:       return a | b;
            2:       return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic set_op(int i, logic [W-1:0] a, logic [W-1:0] b, int op);
        op_a[i*W +: W] = a;
        op_b[i*W +: W] = b;
        op_sel[i*2 +: 2] = 2'(op);
    endtask

    // Predict one clock edge from the rules, advance, then check.
    task automatic cycle();
        logic [NREQ-1:0] n_gnt;
        int n_ptr, n_last, w;
        bit n_s1v, n_outv, n_lastv, rst, locked;
        n_gnt = '0; n_ptr = m_ptr; n_s1v = m_s1v; n_outv = m_outv;
        n_last = m_last; n_lastv = m_last_v; rst = reset;
        w = -1; locked = 0;
        if (reset) begin
            n_ptr = 0; n_s1v = 0; n_outv = 0; n_lastv = 0; n_last = 0;
        end else if (!(m_outv && !rsp_ready)) begin
`ifdef GATE_ARB_LOCK_EN
            if (m_last_v && req[m_last] && lock[m_last]) begin
                w = m_last;
                locked = 1;
            end
`endif
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_ptr + k) % NREQ;
                if (w < 0 && req[j] && !m_gnt[j]) w = j;
            end
            if (w >= 0) begin
                exp_t e;
                e.id = w;
                e.d = ref_op(int'(op_sel[w*2 +: 2]),
                             op_a[w*W +: W], op_b[w*W +: W]);
                exp_q.push_back(e);
                n_gnt[w] = 1'b1;
                if (!locked) n_ptr = (w + 1) % NREQ;
                n_last = w;
                n_lastv = 1;
            end
            n_outv = m_s1v;
            n_s1v = (w >= 0);
        end
        @(posedge clk);
        #1;
        m_gnt = n_gnt; m_ptr = n_ptr; m_s1v = n_s1v; m_outv = n_outv;
        m_last = n_last; m_last_v = n_lastv;
        if (rst) exp_q.delete();
        chk("gnt", 32'(gnt), 32'(m_gnt));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_outv));
    endtask

    // Monitor: every accepted response must match the queue head.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got id %0d data %0h expected none",
                         rsp_id, rsp_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_data", 32'(rsp_data), 32'(e.d));
            end
        end
    end

    initial begin
        logic [W-1:0] r0;
        reset = 1'b1; req = '0; op_a = '0; op_b = '0; op_sel = '0;
        rsp_ready = 1'b1;
`ifdef GATE_ARB_LOCK_EN
        lock = '0;
`endif
        m_ptr = 0; m_gnt = '0; m_s1v = 0; m_outv = 0;
        m_last = 0; m_last_v = 0;

        // reset then idle
        for (int c = 0; c < 4; c++) begin
            if (c == 2) reset = 1'b0;
            cycle();
            chk("idle_id", 32'(rsp_id), 32'd0);
            chk("idle_data", 32'(rsp_data), 32'd0);
        end

        // single AND op
        set_op(0, 8'hF0, 8'h3C, 0);
        req = 4'b0001;
        cycle();
        chk("single_gnt", 32'(gnt), 32'h1);
        req = '0;
        cycle();
        chk("single_data", 32'(rsp_data), 32'h30);
        chk("single_id", 32'(rsp_id), 32'd0);
        cycle();

        // fairness, all XOR, re-requesting after each grant
        reset = 1'b1; cycle(); reset = 1'b0;
        for (int i = 0; i < NREQ; i++)
            set_op(i, 8'(8'h11 * (i + 1)), 8'(8'h5A + i), 2);
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("fair_order", 32'(gnt), 32'(1 << (k % NREQ)));
            for (int i = 0; i < NREQ; i++)
                if (m_gnt[i]) set_op(i, 8'($urandom), 8'($urandom), 2);
        end
        req = '0;
        for (int k = 0; k < 3; k++) cycle();

        // back-pressure
        set_op(0, 8'hA5, 8'h0F, 1);
        set_op(1, 8'hCC, 8'hAA, 3);
        r0 = ref_op(1, 8'hA5, 8'h0F);
        req = 4'b0011;
        cycle();
        req = 4'b0010;
        cycle();
        req = '0;
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("stall_data", 32'(rsp_data), 32'(r0));
            chk("stall_id", 32'(rsp_id), 32'd0);
        end
        rsp_ready = 1'b1;
        cycle();
        chk("resume_id", 32'(rsp_id), 32'd1);
        set_op(0, 8'h12, 8'h34, 2);
        set_op(2, 8'h56, 8'h78, 0);
        req = 4'b0101;
        cycle();
        chk("resume_ptr", 32'(gnt), 32'h4);
        req = '0;
        cycle();

        // wrap-around, then reset with stage 1 full
        set_op(3, 8'h0F, 8'hFF, 3);
        set_op(0, 8'h81, 8'h18, 1);
        req = 4'b1001;
        cycle();
        chk("wrap_gnt3", 32'(gnt), 32'h8);
        req = 4'b0001;
        cycle();
        chk("wrap_gnt0", 32'(gnt), 32'h1);
        req = '0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) cycle();

`ifdef GATE_ARB_LOCK_EN
        // locked burst
        reset = 1'b1; cycle(); reset = 1'b0;
        set_op(1, 8'h3C, 8'hC3, 2);
        set_op(2, 8'h77, 8'h70, 0);
        req = 4'b0110;
        lock = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("lock_gnt", 32'(gnt), 32'h2);
            set_op(1, 8'($urandom), 8'($urandom), 2);
        end
        lock = '0;
        req = 4'b0100;
        cycle();
        chk("lock_release", 32'(gnt), 32'h4);
        req = '0;
        for (int k = 0; k < 3; k++) cycle();
`endif

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (m_gnt[i]) begin
                    if ($urandom_range(1, 0) == 1)
                        set_op(i, 8'($urandom), 8'($urandom),
                               int'($urandom_range(3, 0)));
                    else
                        req[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom_range(9, 0) < 3) begin
                        set_op(i, 8'($urandom), 8'($urandom),
                               int'($urandom_range(3, 0)));
                        req[i] = 1'b1;
                    end
                end else if ($urandom_range(19, 0) == 0) begin
                    req[i] = 1'b0;
                end
            end
`ifdef GATE_ARB_LOCK_EN
            for (int i = 0; i < NREQ; i++)
                lock[i] = ($urandom_range(3, 0) == 0);
`endif
            rsp_ready = ($urandom_range(9, 0) < 7);
            reset = ($urandom_range(199, 0) == 0);
            cycle();
        end

        // drain with a bounded budget
        reset = 1'b0;
        req = '0;
        rsp_ready = 1'b1;
`ifdef GATE_ARB_LOCK_EN
        lock = '0;
`endif
        for (int k = 0; k < 20; k++) begin
            if (exp_q.size() == 0 && !m_outv) break;
            cycle();
        end
        cycle();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
